// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
package mem_bus_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef enum logic {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_bus_rr_pick.sv
// Combinational two-way round-robin pick: on a tie the requester not granted last wins.
module mem_bus_rr_pick
    import mem_bus_pkg::*;
(
    input  logic    m0_valid,
    input  logic    m1_valid,
    input  req_id_t last_grant,
    output req_id_t grant
);

    always_comb begin
        grant = REQ_M0;
        if (m0_valid && m1_valid) begin
            grant = (last_grant == REQ_M0) ? REQ_M1 : REQ_M0;
        end else if (m1_valid) begin
            grant = REQ_M1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for a single-port memory bus with a fixed read latency of RD_LAT.
// Define MEM_BUS_ARBITER_FIXED_PRIO_EN to make m0 win every tie (no last-grant register).
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              m0_valid_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    input  logic [STRB_W-1:0] m0_wstrb_i,
    output logic              m0_ready_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_valid_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic [STRB_W-1:0] m1_wstrb_i,
    output logic              m1_ready_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic [ADDR_W-1:0] address_o,
    output logic [DATA_W-1:0] data_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              we_o,
    output logic [STRB_W-1:0] we_ram_o
);

    state_t            state;
    logic [2:0]        wait_cnt;
    req_id_t           grant_q;
    req_id_t           pick;
    req_id_t           last_grant;
    logic [DATA_W-1:0] rdata_q;
    logic              enter_resp;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;
    logic [STRB_W-1:0] pick_wstrb;

    mem_bus_rr_pick u_pick (
        .m0_valid   (m0_valid_i),
        .m1_valid   (m1_valid_i),
        .last_grant (last_grant),
        .grant      (pick)
    );

    always_comb begin
        pick_addr  = m0_addr_i;
        pick_wdata = m0_wdata_i;
        pick_wstrb = m0_wstrb_i;
        if (pick == REQ_M1) begin
            pick_addr  = m1_addr_i;
            pick_wdata = m1_wdata_i;
            pick_wstrb = m1_wstrb_i;
        end
    end

    // Read data is captured on the same edge that enters RESP, RD_LAT edges after ADDR began.
    assign enter_resp = ((state == ADDR) && (RD_LAT == 1)) ||
                        ((state == WAIT) && (wait_cnt == 3'd1));

`ifdef MEM_BUS_ARBITER_FIXED_PRIO_EN
    assign last_grant = REQ_M1;
`else
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            last_grant <= REQ_M1;
        end else if ((state == IDLE) && (m0_valid_i || m1_valid_i)) begin
            last_grant <= pick;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            grant_q    <= REQ_M0;
            address_o  <= '0;
            data_o     <= '0;
            we_o       <= 1'b0;
            we_ram_o   <= '0;
            m0_ready_o <= 1'b0;
            m1_ready_o <= 1'b0;
            rdata_q    <= '0;
        end else begin
            address_o  <= '0;
            we_o       <= 1'b0;
            we_ram_o   <= '0;
            m0_ready_o <= 1'b0;
            m1_ready_o <= 1'b0;
            if (enter_resp) begin
                state      <= RESP;
                rdata_q    <= data_i;
                m0_ready_o <= (grant_q == REQ_M0);
                m1_ready_o <= (grant_q == REQ_M1);
            end else begin
                case (state)
                    IDLE: begin
                        if (m0_valid_i || m1_valid_i) begin
                            grant_q   <= pick;
                            address_o <= pick_addr;
                            data_o    <= pick_wdata;
                            we_ram_o  <= pick_wstrb;
                            we_o      <= |pick_wstrb;
                            state     <= ADDR;
                        end
                    end
                    ADDR: begin
                        state    <= WAIT;
                        wait_cnt <= 3'(RD_LAT - 1);
                    end
                    WAIT:    wait_cnt <= wait_cnt - 3'd1;
                    RESP:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign m0_rdata_o = rdata_q;
    assign m1_rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (RD_LAT=1 and RD_LAT=4) checked every cycle
// against a timing model, plus directed transactions with hand-computed expectations.
module tb_mem_bus_arbiter;

    logic        clk_i;
    logic        rst_n = 1'b0;
    logic        m0_valid[2], m1_valid[2];
    logic [31:0] m0_addr[2], m1_addr[2], m0_wdata[2], m1_wdata[2];
    logic [3:0]  m0_wstrb[2], m1_wstrb[2];
    logic        m0_ready[2], m1_ready[2];
    logic [31:0] m0_rdata[2], m1_rdata[2];
    logic [31:0] address[2], data_out[2], data_i[2];
    logic        we[2];
    logic [3:0]  we_ram[2];

    int tests = 0;
    int fails = 0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %h, expected %h", nm, d, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 4;

        mem_bus_arbiter #(.ADDR_W(32), .RD_LAT(LAT)) u_dut (
            .clk_i      (clk_i),
            .reset_ni   (rst_n),
            .m0_valid_i (m0_valid[g]),
            .m0_addr_i  (m0_addr[g]),
            .m0_wdata_i (m0_wdata[g]),
            .m0_wstrb_i (m0_wstrb[g]),
            .m0_ready_o (m0_ready[g]),
            .m0_rdata_o (m0_rdata[g]),
            .m1_valid_i (m1_valid[g]),
            .m1_addr_i  (m1_addr[g]),
            .m1_wdata_i (m1_wdata[g]),
            .m1_wstrb_i (m1_wstrb[g]),
            .m1_ready_o (m1_ready[g]),
            .m1_rdata_o (m1_rdata[g]),
            .address_o  (address[g]),
            .data_o     (data_out[g]),
            .data_i     (data_i[g]),
            .we_o       (we[g]),
            .we_ram_o   (we_ram[g])
        );

        // Model: a grant at edge e owns the address cycle starting at e, the response cycle
        // starting at e+LAT, and the bus is free to grant again from edge e+LAT+2.
        int          cyc, e, gnt;
        bit          act, last, rd;
        logic [31:0] ex_addr, ex_data, ex_rdata;
        logic [3:0]  ex_ws;
        logic        ex_we, ex_r0, ex_r1;

        initial begin
            act = 0; last = 1; rd = 0; cyc = 0; e = 0; gnt = 0;
            ex_addr = 0; ex_data = 0; ex_rdata = 0; ex_ws = 0; ex_we = 0; ex_r0 = 0; ex_r1 = 0;
            forever begin
                @(posedge clk_i or negedge rst_n);
                if (!rst_n) begin
                    act = 0; last = 1; cyc = 0;
                    ex_addr = 0; ex_data = 0; ex_ws = 0; ex_we = 0; ex_r0 = 0; ex_r1 = 0;
                end else begin
                    cyc++;
                    ex_addr = 0; ex_we = 0; ex_ws = 0; ex_r0 = 0; ex_r1 = 0;
                    if (act && cyc == e + LAT) begin
                        ex_r0 = (gnt == 0);
                        ex_r1 = (gnt == 1);
                        ex_rdata = data_i[g];
                    end
                    if ((!act || cyc >= e + LAT + 2) && (m0_valid[g] || m1_valid[g])) begin
                        if (m0_valid[g] && m1_valid[g]) begin
`ifdef MEM_BUS_ARBITER_FIXED_PRIO_EN
                            gnt = 0;
`else
                            gnt = last ? 0 : 1;
`endif
                        end else begin
                            gnt = m0_valid[g] ? 0 : 1;
                        end
                        last = (gnt == 1);
                        act = 1;
                        e = cyc;
                        ex_addr = (gnt == 1) ? m1_addr[g] : m0_addr[g];
                        ex_data = (gnt == 1) ? m1_wdata[g] : m0_wdata[g];
                        ex_ws   = (gnt == 1) ? m1_wstrb[g] : m0_wstrb[g];
                        ex_we   = |ex_ws;
                        rd      = (ex_ws == 4'h0);
                    end
                end
            end
        end

        initial forever begin
            @(negedge clk_i);
            chk("cyc address_o", g, address[g], ex_addr);
            chk("cyc data_o", g, data_out[g], ex_data);
            chk("cyc we_o", g, 32'(we[g]), 32'(ex_we));
            chk("cyc we_ram_o", g, 32'(we_ram[g]), 32'(ex_ws));
            chk("cyc m0_ready_o", g, 32'(m0_ready[g]), 32'(ex_r0));
            chk("cyc m1_ready_o", g, 32'(m1_ready[g]), 32'(ex_r1));
            if (ex_r0 && rd) chk("cyc m0_rdata_o", g, m0_rdata[g], ex_rdata);
            if (ex_r1 && rd) chk("cyc m1_rdata_o", g, m1_rdata[g], ex_rdata);
        end
    end

    task automatic req(input int d, input int m, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws);
        if (m == 0) begin
            m0_valid[d] = 1'b1; m0_addr[d] = a; m0_wdata[d] = wd; m0_wstrb[d] = ws;
        end else begin
            m1_valid[d] = 1'b1; m1_addr[d] = a; m1_wdata[d] = wd; m1_wstrb[d] = ws;
        end
    endtask

    task automatic drop(input int d, input int m);
        if (m == 0) m0_valid[d] = 1'b0;
        else        m1_valid[d] = 1'b0;
    endtask

    // Counts negedges from the request cycle (1 = request cycle) until requester m sees ready.
    task automatic wait_ready(input int d, input int m, output int n, output logic [31:0] rd,
                              output logic [31:0] as, output int ac, output int wc,
                              output logic [3:0] ws, output int other);
        n = -1; rd = '0; as = '0; ac = 0; wc = 0; ws = '0; other = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_i);
            if (address[d] != 32'h0) begin as = address[d]; ac++; end
            if (we[d]) begin wc++; ws = we_ram[d]; end
            if ((m == 0) ? m1_ready[d] : m0_ready[d]) other++;
            if ((m == 0) ? m0_ready[d] : m1_ready[d]) begin
                n = i;
                rd = (m == 0) ? m0_rdata[d] : m1_rdata[d];
                break;
            end
        end
        @(posedge clk_i);
        #2;
    endtask

    task automatic burst(input int d, input int m, input int cnt, input logic [31:0] base);
        int n, ac, wc, other;
        logic [31:0] rd, as;
        logic [3:0] ws;
        for (int k = 0; k < cnt; k++) begin
            req(d, m, base + 32'(4 * k), 32'h0, 4'h0);
            wait_ready(d, m, n, rd, as, ac, wc, ws, other);
            chk("burst completes", d, 32'(n > 0), 32'd1);
        end
        drop(d, m);
    endtask

    int          n, ac, wc, other;
    logic [31:0] rd, as;
    logic [3:0]  ws;
    int          ord[4], at[4];

    initial begin
        for (int d = 0; d < 2; d++) begin
            m0_valid[d] = 0; m1_valid[d] = 0; m0_addr[d] = 0; m1_addr[d] = 0;
            m0_wdata[d] = 0; m1_wdata[d] = 0; m0_wstrb[d] = 0; m1_wstrb[d] = 0; data_i[d] = 0;
        end
        repeat (2) @(posedge clk_i);
        #3;
        for (int d = 0; d < 2; d++) begin
            chk("reset address_o", d, address[d], 32'h0);
            chk("reset data_o", d, data_out[d], 32'h0);
            chk("reset rdata_o", d, m0_rdata[d], 32'h0);
            chk("reset ready", d, 32'({m0_ready[d], m1_ready[d], we[d]}), 32'h0);
        end
        @(negedge clk_i);
        rst_n = 1'b1;
        @(posedge clk_i);
        #2;

        // m0 read, RD_LAT=1
        data_i[0] = 32'hDEADBEEF;
        req(0, 0, 32'h0000_1000, 32'h0, 4'h0);
        wait_ready(0, 0, n, rd, as, ac, wc, ws, other);
        drop(0, 0);
        chk("read latency", 0, n, 3);
        chk("read rdata", 0, rd, 32'hDEADBEEF);
        chk("read address", 0, as, 32'h0000_1000);
        chk("read address cycles", 0, ac, 1);
        chk("read we cycles", 0, wc, 0);

        // m1 write
        req(0, 1, 32'h0000_2004, 32'h1234_5678, 4'b0011);
        wait_ready(0, 1, n, rd, as, ac, wc, ws, other);
        drop(0, 1);
        chk("write latency", 0, n, 3);
        chk("write address", 0, as, 32'h0000_2004);
        chk("write we cycles", 0, wc, 1);
        chk("write we_ram", 0, 32'(ws), 32'h3);
        chk("write m0 ready stays 0", 0, other, 0);
        chk("write data_o", 0, data_out[0], 32'h1234_5678);

        // m1 arrives mid-transaction of m0
        req(0, 0, 32'h0000_1100, 32'h0, 4'h0);
        @(negedge clk_i);
        @(posedge clk_i);
        #2;
        req(0, 1, 32'h0000_1200, 32'hAAAA_5555, 4'hF);
        wait_ready(0, 0, n, rd, as, ac, wc, ws, other);
        drop(0, 0);
        chk("late m1 m0 latency", 0, n, 2);
        chk("late m1 m0 address", 0, as, 32'h0000_1100);
        wait_ready(0, 1, n, rd, as, ac, wc, ws, other);
        chk("late m1 latency", 0, n, 3);
        chk("late m1 address", 0, as, 32'h0000_1200);

        // single requester granted back-to-back with one idle cycle
        req(0, 1, 32'h0000_2100, 32'h0, 4'h0);
        wait_ready(0, 1, n, rd, as, ac, wc, ws, other);
        drop(0, 1);
        chk("solo m1 latency", 0, n, 3);
        chk("solo m1 address", 0, as, 32'h0000_2100);

        // both valid continuously after reset
        rst_n = 1'b0;
        #10;
        rst_n = 1'b1;
        fork
            burst(0, 0, 2, 32'h0000_0100);
            burst(0, 1, 2, 32'h0000_0200);
            begin
                int k;
                k = 0;
                for (int i = 1; i <= 60 && k < 4; i++) begin
                    @(negedge clk_i);
                    if (m0_ready[0]) begin ord[k] = 0; at[k] = i; k++; end
                    else if (m1_ready[0]) begin ord[k] = 1; at[k] = i; k++; end
                end
                chk("tie pulses seen", 0, k, 4);
            end
        join
        chk("tie grant 0", 0, ord[0], 0);
        chk("tie grant 1", 0, ord[1], 1);
        chk("tie grant 2", 0, ord[2], 0);
        chk("tie grant 3", 0, ord[3], 1);
        chk("tie first ready", 0, at[0], 3);
        chk("tie gap 1", 0, at[1] - at[0], 3);
        chk("tie gap 2", 0, at[2] - at[1], 3);
        chk("tie gap 3", 0, at[3] - at[2], 3);

        // RD_LAT=4 read, data_i valid only in the capture cycle
        data_i[1] = 32'h1000_0000;
        req(1, 0, 32'h0000_3000, 32'h0, 4'h0);
        fork
            wait_ready(1, 0, n, rd, as, ac, wc, ws, other);
            for (int k = 1; k <= 6; k++) begin
                @(posedge clk_i);
                #1;
                data_i[1] = (k == 4) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(k);
            end
        join
        drop(1, 0);
        chk("lat4 latency", 1, n, 6);
        chk("lat4 rdata", 1, rd, 32'hDEADBEEF);
        chk("lat4 address", 1, as, 32'h0000_3000);
        chk("lat4 address cycles", 1, ac, 1);

        req(1, 1, 32'h0000_3004, 32'hCAFE_F00D, 4'hF);
        wait_ready(1, 1, n, rd, as, ac, wc, ws, other);
        drop(1, 1);
        chk("lat4 write latency", 1, n, 6);
        chk("lat4 write we cycles", 1, wc, 1);
        chk("lat4 write we_ram", 1, 32'(ws), 32'hF);

        // reset during WAIT
        req(1, 1, 32'h0000_4000, 32'h5A5A_5A5A, 4'h0);
        repeat (3) @(negedge clk_i);
        chk("pre-reset data_o", 1, data_out[1], 32'h5A5A_5A5A);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid reset address_o", 1, address[1], 32'h0);
        chk("mid reset data_o", 1, data_out[1], 32'h0);
        chk("mid reset rdata_o", 1, m1_rdata[1], 32'h0);
        chk("mid reset strobes", 1, 32'({we[1], we_ram[1], m0_ready[1], m1_ready[1]}), 32'h0);
        drop(1, 1);
        @(posedge clk_i);
        #2;
        req(1, 1, 32'h0000_4400, 32'h0, 4'h0);
        rst_n = 1'b1;
        wait_ready(1, 1, n, rd, as, ac, wc, ws, other);
        drop(1, 1);
        chk("post-reset latency", 1, n, 6);
        chk("post-reset address", 1, as, 32'h0000_4400);

        repeat (3) @(posedge clk_i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
